// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory arbiter.
//   - WBH access-mode encodings (word/byte/half/rotate)
//   - default memory depth in words
//   - arbiter FSM state encoding
//   - is_bad(): range/alignment check applied when an access is latched
package dm_pkg;

    localparam int unsigned DM_WORDS_DEF = 3072;

    typedef enum logic [1:0] {
        WBH_WORD = 2'b00,
        WBH_BYTE = 2'b01,
        WBH_HALF = 2'b10,
        WBH_ROT  = 2'b11
    } wbh_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // Out of range, or misaligned for word/half. Byte and rotate accept any address.
    function automatic logic is_bad(input logic [31:0] addr, input logic [1:0] wbh,
                                    input int unsigned words);
        logic [31:0] lim;
        lim = 32'(words) << 2;
        return (addr >= lim)
            || (wbh == WBH_WORD && addr[1:0] != 2'b00)
            || (wbh == WBH_HALF && addr[0]);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : requests
//   advance    : a grant was taken this cycle; remember who won
//   gnt[1:0]   : combinational one-hot grant
// On a tie the port not granted last wins. The pointer resets to port 1 so
// port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_d = advance ? gnt[1] : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between the CPU memory stage
// (port 0) and a DMA/debug loader (port 1).
//   Clk, Reset          : clock, synchronous active-high reset
//   reqN/weN/wbhN       : request, store flag, access mode per port
//   addrN/wdataN/pcN    : byte address, store data, write-log tag per port
//   gntN                : combinational acceptance pulse (arbitration cycle)
//   rvalidN, rdata, err : registered response, two cycles after gnt
//   mem_*               : memory drive, live only during the ACCESS cycle
//   mem_dout            : memory combinational read data
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  wbh0,
    input  logic [1:0]  wbh1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] pc0,
    input  logic [31:0] pc1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [1:0]  mem_wbh,
    output logic [31:0] mem_a,
    output logic [31:0] mem_din,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_dout
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [1:0]  wbh_q, wbh_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic        bad_q, bad_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  arb_gnt;
    logic [1:0]  gnt_w;
    logic        arb_en;
    logic        in_acc;

    // Arbitration is blocked during ACCESS and while Reset is high, so the
    // pointer only moves on a grant that is actually taken.
    rr_arb2 u_arb (
        .clk     (Clk),
        .reset   (Reset),
        .req     ({req1, req0}),
        .advance (|gnt_w),
        .gnt     (arb_gnt)
    );

    always_comb begin
        arb_en  = (state_q != ACCESS) && !Reset;
        gnt_w   = arb_gnt & {2{arb_en}};

        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        wbh_d   = wbh_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;

        if (|gnt_w) begin
            owner_d = gnt_w[1];
            we_d    = gnt_w[1] ? we1    : we0;
            wbh_d   = gnt_w[1] ? wbh1   : wbh0;
            addr_d  = gnt_w[1] ? addr1  : addr0;
            wdata_d = gnt_w[1] ? wdata1 : wdata0;
            pc_d    = gnt_w[1] ? pc1    : pc0;
            bad_d   = is_bad(addr_d, wbh_d, DM_WORDS);
        end

        case (state_q)
            IDLE:    if (|gnt_w) state_d = ACCESS;
            ACCESS: begin
                // Stores and rejected accesses report zero data.
                rdata_d = (we_q || bad_q) ? 32'd0 : mem_dout;
                state_d = RESP;
            end
            RESP:    state_d = (|gnt_w) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            wbh_q   <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            wbh_q   <= wbh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory drive is decoded from state registers only; Reset gates the
    // write strobe so an in-flight store is dropped in the same cycle.
    assign in_acc  = (state_q == ACCESS);
    assign mem_we  = in_acc && we_q && !bad_q && !Reset;
    assign mem_wbh = in_acc ? wbh_q   : 2'b00;
    assign mem_a   = in_acc ? addr_q  : 32'd0;
    assign mem_din = in_acc ? wdata_q : 32'd0;
    assign mem_pc  = in_acc ? pc_q    : 32'd0;

    assign gnt0    = gnt_w[0];
    assign gnt1    = gnt_w[1];
    assign rvalid0 = (state_q == RESP) && !owner_q;
    assign rvalid1 = (state_q == RESP) &&  owner_q;
    assign err     = (state_q == RESP) &&  bad_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int WORDS = 3072;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [1:0]  wbh0, wbh1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
    logic [1:0]  mem_wbh;
    logic [31:0] rdata, mem_a, mem_din, mem_pc, mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:WORDS-1];

    dm_arbiter #(.DM_WORDS(WORDS)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .wbh0(wbh0), .wbh1(wbh1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .pc0(pc0), .pc1(pc1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err),
        .mem_we(mem_we), .mem_wbh(mem_wbh), .mem_a(mem_a),
        .mem_din(mem_din), .mem_pc(mem_pc), .mem_dout(mem_dout)
    );

    always #5 Clk = ~Clk;

    // Behavioural data memory: little-endian lanes, combinational read,
    // synchronous write. Rotate reads rotate right by the byte offset and
    // rotate writes rotate left by it.
    always_comb begin
        logic [31:0] w;
        logic [4:0]  sh;
        w  = (mem_a[31:2] < WORDS) ? mem[mem_a[13:2]] : 32'd0;
        sh = {mem_a[1:0], 3'b000};
        case (mem_wbh)
            2'b00:   mem_dout = w;
            2'b01:   mem_dout = {24'd0, 8'(w >> sh)};
            2'b10:   mem_dout = {16'd0, 16'(w >> {mem_a[1], 4'b0000})};
            default: mem_dout = (w >> sh) | (w << (6'd32 - {1'b0, sh}));
        endcase
    end

    always @(posedge Clk) begin
        if (mem_we && mem_a[31:2] < WORDS) begin
            case (mem_wbh)
                2'b00: mem[mem_a[13:2]] = mem_din;
                2'b01: mem[mem_a[13:2]][mem_a[1:0]*8 +: 8] = mem_din[7:0];
                2'b10: mem[mem_a[13:2]][mem_a[1]*16 +: 16] = mem_din[15:0];
                default: mem[mem_a[13:2]] = (mem_din << {mem_a[1:0], 3'b000})
                                          | (mem_din >> (6'd32 - {1'b0, mem_a[1:0], 3'b000}));
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One complete transaction: gnt at N, memory cycle at N+1, response at N+2.
    task automatic access(input int port, input logic we, input logic [1:0] wbh,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er,
                          output logic we_seen, output logic [31:0] a_seen);
        int n;
        @(posedge Clk); #1;
        if (port == 0) begin
            req0 = 1; we0 = we; wbh0 = wbh; addr0 = addr; wdata0 = wdata; pc0 = 32'h100 + addr;
        end else begin
            req1 = 1; we1 = we; wbh1 = wbh; addr1 = addr; wdata1 = wdata; pc1 = 32'h200 + addr;
        end
        n = 0;
        @(negedge Clk);
        while (!(port == 0 ? gnt0 : gnt1) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("gnt_seen", 32'(port == 0 ? gnt0 : gnt1), 32'd1);
        @(posedge Clk); #1;
        req0 = 0; req1 = 0;
        @(negedge Clk);
        we_seen = mem_we;
        a_seen  = mem_a;
        chk("no_gnt_in_access", {30'd0, gnt1, gnt0}, 32'd0);
        @(negedge Clk);
        chk("rvalid_owner", 32'(port == 0 ? rvalid0 : rvalid1), 32'd1);
        chk("rvalid_other", 32'(port == 0 ? rvalid1 : rvalid0), 32'd0);
        rd = rdata;
        er = err;
    endtask

    logic [31:0] rd, as;
    logic        er, ws;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
        Reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; wbh0 = 0; wbh1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0; pc1 = 0;
        repeat (2) @(posedge Clk);
        #1 req0 = 1;
        @(negedge Clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_din", mem_din | mem_pc | 32'(mem_wbh), 32'd0);
        @(posedge Clk); #1;
        Reset = 0; req0 = 0;

        // Tie with both held: first grant to port 0, then alternate every 2 cycles.
        @(posedge Clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; wbh0 = 2'b00; wbh1 = 2'b00;
        addr0 = 32'h10; addr1 = 32'h8;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk($sformatf("rr_gnt%0d", i), {30'd0, gnt1, gnt0},
                (i % 2 == 1) ? 32'd0 : ((i % 4 == 0) ? 32'd1 : 32'd2));
            chk($sformatf("rr_rv_excl%0d", i), 32'(rvalid0 & rvalid1), 32'd0);
        end
        @(posedge Clk); #1;
        req0 = 0; req1 = 0;
        repeat (2) @(posedge Clk);

        // Single store then load-back through the other port.
        access(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, ws, as);
        chk("st_mem_we", 32'(ws), 32'd1);
        chk("st_mem_a", as, 32'h10);
        chk("st_err", 32'(er), 32'd0);
        access(1, 0, 2'b00, 32'h10, 32'h0, rd, er, ws, as);
        chk("ld_data", rd, 32'hDEADBEEF);
        chk("ld_mem_we", 32'(ws), 32'd0);

        // Byte and half lanes.
        access(0, 1, 2'b00, 32'h10, 32'h11223344, rd, er, ws, as);
        access(1, 1, 2'b01, 32'h13, 32'h000000AB, rd, er, ws, as);
        chk("byte_st_err", 32'(er), 32'd0);
        access(0, 0, 2'b00, 32'h10, 32'h0, rd, er, ws, as);
        chk("byte_word_ld", rd, 32'hAB223344);
        access(0, 0, 2'b10, 32'h12, 32'h0, rd, er, ws, as);
        chk("half_ld", rd, 32'h0000AB22);

        // Range and alignment errors.
        access(0, 1, 2'b00, 32'h6, 32'h12345678, rd, er, ws, as);
        chk("mis_st_err", 32'(er), 32'd1);
        chk("mis_st_no_we", 32'(ws), 32'd0);
        chk("mis_st_rdata", rd, 32'd0);
        access(0, 0, 2'b00, 32'h4, 32'h0, rd, er, ws, as);
        chk("mis_st_unchanged", rd, 32'd0);
        access(1, 0, 2'b00, 32'h3000, 32'h0, rd, er, ws, as);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        access(1, 1, 2'b00, 32'h2FFC, 32'h0BADCAFE, rd, er, ws, as);
        chk("last_word_err", 32'(er), 32'd0);
        access(0, 0, 2'b00, 32'h2FFC, 32'h0, rd, er, ws, as);
        chk("last_word_ld", rd, 32'h0BADCAFE);
        access(0, 0, 2'b10, 32'h11, 32'h0, rd, er, ws, as);
        chk("half_mis_err", 32'(er), 32'd1);

        // Rotate and byte loads.
        access(0, 1, 2'b00, 32'h8, 32'h11223344, rd, er, ws, as);
        access(1, 0, 2'b11, 32'h9, 32'h0, rd, er, ws, as);
        chk("rot_ld", rd, 32'h44112233);
        chk("rot_err", 32'(er), 32'd0);
        access(1, 0, 2'b01, 32'h9, 32'h0, rd, er, ws, as);
        chk("byte_ld", rd, 32'h00000033);

        // Reset during the ACCESS cycle of a store.
        @(posedge Clk); #1;
        req0 = 1; we0 = 1; wbh0 = 2'b00; addr0 = 32'h20; wdata0 = 32'h5;
        @(negedge Clk);
        chk("mid_gnt0", 32'(gnt0), 32'd1);
        @(posedge Clk); #1;
        req0 = 0; Reset = 1;
        @(negedge Clk);
        chk("mid_mem_we", 32'(mem_we), 32'd0);
        @(posedge Clk); #1;
        Reset = 0;
        @(negedge Clk);
        chk("mid_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_mem", 32'(mem_we) | mem_a | mem_din | mem_pc, 32'd0);
        chk("mid_no_write", mem[8], 32'd0);
        @(posedge Clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h10;
        @(negedge Clk);
        chk("mid_tie_port0", {30'd0, gnt1, gnt0}, 32'd1);
        @(posedge Clk); #1;
        req0 = 0; req1 = 0;
        repeat (3) @(posedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Sequencing controller that shares the single-port data memory between two requesters: the CPU memory stage (port 0) and a DMA/debug loader (port 1). It arbitrates round-robin, checks address range and alignment, and drives the memory's write-enable, access-mode, address and data lines for exactly one cycle per access. It returns a registered read-data/acknowledge response to the winning requester. It sits between the requesters and the data memory. The memory has a combinational read path, a synchronous write and 3072 32-bit words.

## Interface

- `DM_WORDS`, 3072: memory depth in words. The valid byte range is 0 to 4*DM_WORDS-1.
- `Clk` input, 1: single clock. Everything is rising-edge.
- `Reset` input, 1: synchronous, active-high.
- `req0`, `req1` input, 1: access request from port 0 and port 1.
- `we0`, `we1` input, 1: 1 = store, 0 = load.
- `wbh0`, `wbh1` input, 2: access mode. 00 = word, 01 = byte, 10 = half, 11 = rotate/replicate.
- `addr0`, `addr1` input, 32: byte address.
- `wdata0`, `wdata1` input, 32: store data.
- `pc0`, `pc1` input, 32: tag that is forwarded to the memory's PC input for the write log.
- `gnt0`, `gnt1` output, 1: one-cycle acceptance pulse.
- `rvalid0`, `rvalid1` output, 1: one-cycle response pulse. Stores get it too.
- `rdata` output, 32: load data. It is valid when either rvalid is high.
- `err` output, 1: error flag for the response. It is valid together with rvalid.
- `mem_we` output, 1: drives the memory's MemWrite.
- `mem_wbh` output, 2: drives the memory's WBH.
- `mem_a` output, 32: drives the memory's A.
- `mem_din` output, 32: drives the memory's Din.
- `mem_pc` output, 32: drives the memory's PC.
- `mem_dout` input, 32: the memory's Dout.

## Operation

- **FSM states:** IDLE, ACCESS, RESP.
- **Arbitration:**
  - Evaluated only in IDLE or RESP.
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - The last-grant pointer resets to "port 1", so port 0 wins the first tie.
- **Grant:**
  - `gntN` is combinational and high in the arbitration cycle.
  - In that cycle the winner's we/wbh/addr/wdata/pc are latched into access registers.
  - The next state is ACCESS.
  - The requester must hold its fields stable while req is high and gnt is low.
  - The requester may change them or drop req in the cycle after gnt.
- **Checks** are performed at the latch and stored as `bad`. An access is bad if:
  - `addr >= 4*DM_WORDS`, or
  - the mode is word and `addr[1:0] != 0`, or
  - the mode is half and `addr[0] != 0`.
  - Byte and rotate modes have no alignment check.
- **ACCESS (exactly 1 cycle):**
  - mem_a, mem_wbh, mem_din and mem_pc drive the latched values.
  - `mem_we = latched_we & ~bad & ~Reset`.
  - `mem_dout` is captured into the rdata register. The value is 0 if bad or if the access is a store.
  - The next state is RESP.
- **RESP (1 cycle):**
  - The owner's `rvalidN` is high, and `err = bad`.
  - Arbitration runs. If anyone requests, grant and go to ACCESS. Otherwise go to IDLE.
- **Idle memory drive:** outside ACCESS, mem_a, mem_din, mem_pc and mem_wbh are driven to 0 and mem_we to 0.
- **Bad accesses** never write memory and always return rdata = 0.
- **Reset:**
  - State goes to IDLE and the pointer to port 1.
  - All outputs go low/0: gnt*, rvalid*, rdata, err and all mem_* outputs.
  - An access in flight when Reset rises is dropped with no response, and its write is suppressed.

## Timing

- Grant at cycle N, memory access at N+1, response (rvalid) at N+2.
- Throughput: one access per 2 cycles while requests are continuous. A new gnt may coincide with the previous rvalid.
- Loads and stores have the same latency.
- gnt never asserts in ACCESS. rvalid0 and rvalid1 are never high in the same cycle.
- A req that rises during ACCESS is first seen in RESP.
- When req0 and req1 are both held continuously, grants alternate 0,1,0,1.

## Structure

- Shared package `dm_pkg`:
  - WBH encodings: WBH_WORD, WBH_BYTE, WBH_HALF, WBH_ROT.
  - DM_WORDS default.
  - FSM state encoding.
- Sub-module `rr_arb2`: two-request round-robin arbiter. It has combinational grant outputs, plus a pointer register updated on an `advance` input.
- The rest is the FSM plus the access/response registers in `dm_arbiter`.

## Test plan

- **Single store:** Reset, then req0 with we=1, wbh=00, addr=0x10, wdata=0xDEADBEEF.
  - gnt0 at N, mem_we=1 at N+1 with mem_a=0x10, rvalid0 at N+2 with err=0.
  - A following load of 0x10 returns 0xDEADBEEF.
- **Tie and round-robin:** req0 and req1 both held continuously, all loads.
  - Grants come out as 0,1,0,1 in cycles N, N+2, N+4, N+6.
  - The first grant after reset goes to port 0.
- **Byte/half lanes:**
  - Store byte 0xAB at addr 0x13 over the word 0x11223344. A word load returns 0xAB223344.
  - A half load at 0x12 returns 0x0000AB22.
- **Errors:**
  - A word store at 0x6 gives err=1, no mem_we pulse, and memory unchanged.
  - A load at 0x3000 (=4*3072) gives err=1 and rdata=0.
- **Reset mid-operation:** assert Reset during ACCESS of a store of 0x5 to 0x20.
  - mem_we=0 that cycle, and no rvalid follows.
  - All outputs are 0 the cycle after.
  - The next tie goes to port 0.
- **Rotate mode:** with the word at 0x8 = 0x11223344, a load with wbh=11 at addr 0x9 returns 0x44112233.
